// File: rtl/mem_line_initiator.sv
// Cache-line initiator on the shared main-memory bus: splits one line request into
// LINE_WORDS single-word RAM transactions with a per-word timeout.
module mem_line_initiator #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int LINE_WORDS     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wline,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_error,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] rsp_rline,
  output logic                             mem_re,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  inout  wire  [DATA_WIDTH-1:0]            mem_data,
  input  logic                             mem_done
);

  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;
  localparam int IDX_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]       wline_q, wline_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [LINE_W-1:0]       rline_q, rline_d;
  logic                    error_q, error_d;
  logic                    re_q, re_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic                    drive_q, drive_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  // Issue-side selection: on accept the request inputs are used directly,
  // afterwards the latched copies, so the RAM strobes come straight from flops.
  logic                    iss;
  logic                    iss_write;
  logic [IDX_W-1:0]        iss_idx;
  logic [ADDR_WIDTH-1:0]   iss_base;
  logic [LINE_W-1:0]       iss_line;

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wline_d   = wline_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    rline_d   = rline_q;
    error_d   = error_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    re_d      = 1'b0;
    we_d      = 1'b0;
    drive_d   = 1'b0;
    iss       = 1'b0;
    iss_write = write_q;
    iss_idx   = idx_q;
    iss_base  = addr_q;
    iss_line  = wline_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          addr_d    = req_addr;
          wline_d   = req_wline;
          idx_d     = '0;
          rline_d   = '0;
          error_d   = 1'b0;
          state_d   = S_ISSUE;
          iss       = 1'b1;
          iss_write = req_write;
          iss_idx   = '0;
          iss_base  = req_addr;
          iss_line  = req_wline;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done) begin
          if (!write_q) rline_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = mem_data;
          if (idx_q == IDX_W'(LINE_WORDS - 1)) begin
            error_d = 1'b0;
            state_d = S_RESP;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
            iss     = 1'b1;
            iss_idx = idx_q + 1'b1;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (iss) begin
      maddr_d = iss_base + ADDR_WIDTH'(iss_idx);
      re_d    = !iss_write;
      we_d    = iss_write;
      drive_d = iss_write;
      wdata_d = iss_line[int'(iss_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wline_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      rline_q <= '0;
      error_q <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      drive_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      rline_q <= rline_d;
      error_q <= error_d;
      re_q    <= re_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      drive_q <= drive_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_error = error_q;
  assign rsp_rline = rline_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  // The bus is driven only during a write ISSUE cycle; reads leave it to the RAM.
  assign mem_data  = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_line_initiator.sv
// Directed bench for mem_line_initiator with a one-cycle-done RAM model.
module tb_mem_line_initiator;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [LW*DW-1:0]  req_wline = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_error;
  logic [LW*DW-1:0]  rsp_rline;
  logic              mem_re;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  wire  [DW-1:0]     mem_data;
  logic              mem_done;

  mem_line_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wline(req_wline),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_error(rsp_error), .rsp_rline(rsp_rline),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  // RAM model: done and read data one cycle after the strobe; ram_nodone suppresses done.
  logic [DW-1:0] ram [0:65535];
  logic          ram_done = 1'b0;
  logic          ram_drv = 1'b0;
  logic [DW-1:0] ram_rd = '0;
  logic          ram_nodone = 1'b0;

  assign mem_data = ram_drv ? ram_rd : {DW{1'bz}};
  assign mem_done = ram_done;

  always @(posedge clk) begin
    if (mem_re) begin
      ram_rd   <= ram[mem_addr];
      ram_done <= !ram_nodone;
      ram_drv  <= !ram_nodone;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_data;
      ram_done <= !ram_nodone;
      ram_drv  <= 1'b0;
    end else begin
      ram_done <= 1'b0;
      ram_drv  <= 1'b0;
    end
  end

  // Bus monitor, sampled on the falling edge.
  int            re_cnt = 0;
  int            we_cnt = 0;
  int            bus_bad = 0;
  logic [AW-1:0] addr_log[$];

  always @(negedge clk) begin
    if (mem_re) begin
      re_cnt++;
      addr_log.push_back(mem_addr);
    end
    if (mem_we) we_cnt++;
    if (mem_re && mem_we) bus_bad++;
    if (!mem_we && !ram_drv && !(mem_data === {DW{1'bz}} || mem_data === {DW{1'b0}})) bus_bad++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [LW*DW-1:0] line,
                      output int lat);
    int g;
    g = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wline = line;
    while (!req_ready && g < 50) begin
      tick();
      g++;
    end
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_drop"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_req_ready_back"}, 64'(req_ready), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          r0, w0, b0, l0;
    logic [63:0] held;

    ram[16'h0100] = 16'hA000;
    ram[16'h0101] = 16'hA111;
    ram[16'h0102] = 16'hA222;
    ram[16'h0103] = 16'hA333;
    ram[16'hFFFE] = 16'hB0FE;
    ram[16'hFFFF] = 16'hB0FF;
    ram[16'h0000] = 16'hB000;
    ram[16'h0001] = 16'hB001;

    // Reset state
    repeat (2) tick();
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_error", 64'(rsp_error), 64'(0));
    chk("rst_rsp_rline", rsp_rline, 64'h0);
    chk("rst_mem_re", 64'(mem_re), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    rst_n = 1'b1;
    tick();

    // 1: line read, latency and strobe count
    r0 = re_cnt;
    l0 = addr_log.size();
    send(1'b0, 16'h0100, '0, lat);
    chk("rd1_latency", 64'(lat), 64'(8));
    chk("rd1_rline", rsp_rline, 64'hA333_A222_A111_A000);
    chk("rd1_error", 64'(rsp_error), 64'(0));
    chk("rd1_re_pulses", 64'(re_cnt - r0), 64'(4));
    chk("rd1_addr0", 64'(addr_log[l0]), 64'h0100);
    chk("rd1_addr3", 64'(addr_log[l0+3]), 64'h0103);
    finish_rsp("rd1");

    // 2: line write then read-back; bus released outside write strobes
    b0 = bus_bad;
    w0 = we_cnt;
    send(1'b1, 16'h0200, 64'h4444_3333_2222_1111, lat);
    chk("wr_latency", 64'(lat), 64'(8));
    chk("wr_rline_zero", rsp_rline, 64'h0);
    chk("wr_error", 64'(rsp_error), 64'(0));
    chk("wr_ram_w0", 64'(ram[16'h0200]), 64'h1111);
    chk("wr_ram_w3", 64'(ram[16'h0203]), 64'h4444);
    finish_rsp("wr");
    send(1'b0, 16'h0200, '0, lat);
    chk("wrrd_rline", rsp_rline, 64'h4444_3333_2222_1111);
    chk("wr_we_cycles", 64'(we_cnt - w0), 64'(4));
    chk("wr_bus_release", 64'(bus_bad - b0), 64'(0));
    finish_rsp("wrrd");

    // 3: address wrap
    l0 = addr_log.size();
    send(1'b0, 16'hFFFE, '0, lat);
    chk("wrap_rline", rsp_rline, 64'hB001_B000_B0FF_B0FE);
    chk("wrap_addr0", 64'(addr_log[l0]), 64'hFFFE);
    chk("wrap_addr1", 64'(addr_log[l0+1]), 64'hFFFF);
    chk("wrap_addr2", 64'(addr_log[l0+2]), 64'h0000);
    chk("wrap_addr3", 64'(addr_log[l0+3]), 64'h0001);
    finish_rsp("wrap");

    // 4: timeout on word 0
    ram_nodone = 1'b1;
    r0 = re_cnt;
    send(1'b0, 16'h0300, '0, lat);
    chk("to_latency", 64'(lat), 64'(17));
    chk("to_error", 64'(rsp_error), 64'(1));
    chk("to_rline", rsp_rline, 64'h0);
    chk("to_re_pulses", 64'(re_cnt - r0), 64'(1));
    finish_rsp("to");
    ram_nodone = 1'b0;

    // 5: response back-pressure
    send(1'b0, 16'h0100, '0, lat);
    chk("bp_error_clear", 64'(rsp_error), 64'(0));
    held = rsp_rline;
    chk("bp_rline", held, 64'hA333_A222_A111_A000);
    r0 = re_cnt;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0200;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rline_stable", rsp_rline, held);
      chk("bp_req_ready", 64'(req_ready), 64'(0));
    end
    req_valid = 1'b0;
    finish_rsp("bp");
    repeat (3) tick();
    chk("bp_no_accept", 64'(re_cnt - r0), 64'(0));

    // 6: reset during WAIT of word 2
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0100;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    chk("rstw_addr_w2", 64'(mem_addr), 64'h0102);
    rst_n = 1'b0;
    #1;
    chk("rstw_mem_re", 64'(mem_re), 64'(0));
    chk("rstw_mem_addr", 64'(mem_addr), 64'h0);
    chk("rstw_rline", rsp_rline, 64'h0);
    chk("rstw_req_ready", 64'(req_ready), 64'(1));
    tick();
    chk("rstw_mem_we", 64'(mem_we), 64'(0));
    chk("rstw_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rstw_bus_released", 64'(mem_data === {DW{1'bz}} || mem_data === {DW{1'b0}}), 64'(1));
    r0 = re_cnt;
    rst_n = 1'b1;
    repeat (10) tick();
    chk("rstw_no_rsp", 64'(rsp_valid), 64'(0));
    chk("rstw_no_resume", 64'(re_cnt - r0), 64'(0));
    chk("rstw_idle", 64'(req_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
